// File: rtl/zero_io_channels.sv
// Input/output channel unit for the zero machine: per-channel input FIFOs filled by a producer,
// output FIFOs drained by a consumer, and an op port (inSize/in/out) with a registered result.
module zero_io_channels #(
    parameter int MemoryElementWidth = 12,
    parameter int NChannels = 2,
    parameter int NIn = 8,
    parameter int NOut = 8,
    parameter bit OutOverwrite = 1'b1,
    localparam int CW = (NChannels > 1) ? $clog2(NChannels) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inPushValid,
    input  logic [CW-1:0]                 inPushChannel,
    input  logic [MemoryElementWidth-1:0] inPushData,
    output logic                          inPushReady,
    input  logic                          opValid,
    input  logic [1:0]                    opCode,
    input  logic [CW-1:0]                 opChannel,
    input  logic [MemoryElementWidth-1:0] opData,
    output logic                          resValid,
    output logic [MemoryElementWidth-1:0] resData,
    output logic                          resError,
    output logic                          outValid,
    input  logic [CW-1:0]                 outSelect,
    output logic [MemoryElementWidth-1:0] outData,
    input  logic                          outTake,
    output logic [15:0]                   outDropped,
    output logic                          debugResp
);

    localparam int IPW = $clog2(NIn);
    localparam int OPW = $clog2(NOut);

    localparam logic [1:0] OpNop    = 2'd0;
    localparam logic [1:0] OpInSize = 2'd1;
    localparam logic [1:0] OpIn     = 2'd2;
    localparam logic [1:0] OpOut    = 2'd3;

    typedef enum logic {Idle, Resp} resStateT;

    resStateT resState, resStateNext;
    logic [MemoryElementWidth-1:0] resDataNext;
    logic resErrorNext;

    logic pushChOk, opChOk, outSelOk;
    logic [CW-1:0] pushIdx, opIdx, outSelIdx;

    logic [IPW:0] inCount [NChannels];
    logic [OPW:0] outCount [NChannels];
    logic [MemoryElementWidth-1:0] inHeadWord [NChannels];
    logic [MemoryElementWidth-1:0] outHeadWord [NChannels];
    logic [NChannels-1:0] takeHit, dropHit;

    // Out-of-range channels are steered to index 0 so array reads stay in bounds; the Ok flags gate any effect.
    assign pushChOk  = (int'(inPushChannel) < NChannels);
    assign opChOk    = (int'(opChannel) < NChannels);
    assign outSelOk  = (int'(outSelect) < NChannels);
    assign pushIdx   = pushChOk ? inPushChannel : '0;
    assign opIdx     = opChOk ? opChannel : '0;
    assign outSelIdx = outSelOk ? outSelect : '0;

    assign inPushReady = pushChOk && (inCount[pushIdx] != (IPW+1)'(NIn));
    assign outValid    = outSelOk && (outCount[outSelIdx] != '0);
    assign outData     = outHeadWord[outSelIdx];

    for (genvar ch = 0; ch < NChannels; ch++) begin : gChan
        logic [MemoryElementWidth-1:0] inMem [NIn];
        logic [MemoryElementWidth-1:0] outMem [NOut];
        logic [IPW-1:0] inHead, inTail;
        logic [OPW-1:0] outHead, outTail;
        logic [IPW:0] inCnt;
        logic [OPW:0] outCnt;
        logic opHere, doPush, doPop, outOpHere, outFull, outWrite, outAdvance;

        assign opHere    = opValid && opChOk && (opIdx == CW'(ch));
        assign doPush    = inPushValid && inPushReady && (pushIdx == CW'(ch));
        assign doPop     = opHere && (opCode == OpIn) && (inCnt != '0);
        assign outOpHere = opHere && (opCode == OpOut);
        assign outFull   = (outCnt == (OPW+1)'(NOut));
        assign takeHit[ch] = outTake && outSelOk && (outSelIdx == CW'(ch)) && (outCnt != '0);
        // A same-cycle take frees the slot, so a full FIFO only drops when nothing is taken.
        assign dropHit[ch] = outOpHere && outFull && !takeHit[ch];
        assign outWrite    = outOpHere && (!outFull || takeHit[ch] || OutOverwrite);
        assign outAdvance  = takeHit[ch] || (outOpHere && outFull && OutOverwrite);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                inHead  <= '0;
                inTail  <= '0;
                inCnt   <= '0;
                outHead <= '0;
                outTail <= '0;
                outCnt  <= '0;
            end else begin
                if (doPush) inTail <= inTail + IPW'(1);
                if (doPop) inHead <= inHead + IPW'(1);
                inCnt <= inCnt + (IPW+1)'(doPush) - (IPW+1)'(doPop);
                if (outWrite) outTail <= outTail + OPW'(1);
                if (outAdvance) outHead <= outHead + OPW'(1);
                outCnt <= outCnt + (OPW+1)'(outWrite) - (OPW+1)'(outAdvance);
            end
        end

        always_ff @(posedge clock) begin
            if (doPush) inMem[inTail] <= inPushData;
            if (outWrite) outMem[outTail] <= opData;
        end

        assign inCount[ch]     = inCnt;
        assign outCount[ch]    = outCnt;
        assign inHeadWord[ch]  = inMem[inHead];
        assign outHeadWord[ch] = outMem[outHead];
    end

    always_comb begin
        resStateNext = Idle;
        resDataNext  = '0;
        resErrorNext = 1'b0;
        if (opValid && (opCode != OpNop)) begin
            resStateNext = Resp;
            if (!opChOk) begin
                resErrorNext = 1'b1;
            end else begin
                case (opCode)
                    OpInSize: resDataNext = MemoryElementWidth'(inCount[opIdx]);
                    OpIn: begin
                        if (inCount[opIdx] == '0) resErrorNext = 1'b1;
                        else resDataNext = inHeadWord[opIdx];
                    end
                    OpOut: resErrorNext = !OutOverwrite && (|dropHit);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resState   <= Idle;
            resData    <= '0;
            resError   <= 1'b0;
            outDropped <= '0;
        end else begin
            resState <= resStateNext;
            resData  <= resDataNext;
            resError <= resErrorNext;
            if ((|dropHit) && (outDropped != 16'hFFFF)) outDropped <= outDropped + 16'd1;
        end
    end

    assign resValid  = (resState == Resp);
    assign debugResp = (resState == Resp);

endmodule

// File: tb/tb_zero_io_channels.sv
// Bench for zero_io_channels: two instances (overwrite and reject on output-full) share stimulus
// and are checked against a queue-based model of the channel rules.
module tb_zero_io_channels;

    localparam int W = 12;
    localparam int NCH = 3;
    localparam int DEPTH = 8;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic inPushValid = 1'b0;
    logic [CW-1:0] inPushChannel = '0;
    logic [W-1:0] inPushData = '0;
    logic opValid = 1'b0;
    logic [1:0] opCode = '0;
    logic [CW-1:0] opChannel = '0;
    logic [W-1:0] opData = '0;
    logic [CW-1:0] outSelect = '0;
    logic outTake = 1'b0;

    logic aPushReady, aResValid, aResError, aOutValid, aDebug;
    logic [W-1:0] aResData, aOutData;
    logic [15:0] aDropped;
    logic bPushReady, bResValid, bResError, bOutValid, bDebug;
    logic [W-1:0] bResData, bOutData;
    logic [15:0] bDropped;

    zero_io_channels #(.MemoryElementWidth(W), .NChannels(NCH), .NIn(DEPTH), .NOut(DEPTH), .OutOverwrite(1'b1)) dutA (
        .clock(clock), .reset(reset),
        .inPushValid(inPushValid), .inPushChannel(inPushChannel), .inPushData(inPushData), .inPushReady(aPushReady),
        .opValid(opValid), .opCode(opCode), .opChannel(opChannel), .opData(opData),
        .resValid(aResValid), .resData(aResData), .resError(aResError),
        .outValid(aOutValid), .outSelect(outSelect), .outData(aOutData), .outTake(outTake),
        .outDropped(aDropped), .debugResp(aDebug)
    );

    zero_io_channels #(.MemoryElementWidth(W), .NChannels(NCH), .NIn(DEPTH), .NOut(DEPTH), .OutOverwrite(1'b0)) dutB (
        .clock(clock), .reset(reset),
        .inPushValid(inPushValid), .inPushChannel(inPushChannel), .inPushData(inPushData), .inPushReady(bPushReady),
        .opValid(opValid), .opCode(opCode), .opChannel(opChannel), .opData(opData),
        .resValid(bResValid), .resData(bResData), .resError(bResError),
        .outValid(bOutValid), .outSelect(outSelect), .outData(bOutData), .outTake(outTake),
        .outDropped(bDropped), .debugResp(bDebug)
    );

    int assertCount = 0;
    int failCount = 0;

    // Reference model: plain queues per channel; the input side is shared by both instances.
    logic [W-1:0] inQ [NCH][$];
    logic [W-1:0] oqA [NCH][$];
    logic [W-1:0] oqB [NCH][$];
    int dropA = 0;
    int dropB = 0;

    logic expReady, expOutValidA, expOutValidB, expResValid, expErrA, expErrB;
    logic [W-1:0] expOutDataA, expOutDataB, expResData;
    logic capReadyA, capReadyB, capValidA, capValidB;
    logic [W-1:0] capDataA, capDataB;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] expB_q[$];

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            inQ[c].delete();
            oqA[c].delete();
            oqB[c].delete();
        end
        dropA = 0;
        dropB = 0;
    endtask

    // Predicts this cycle's outcome from the model, samples combinational outputs, then clocks.
    task automatic step();
        logic tkA, tkB;
        int c, s;
        #1;
        s = int'(outSelect);
        c = int'(opChannel);
        expReady = 1'b0;
        if (int'(inPushChannel) < NCH) expReady = (inQ[inPushChannel].size() < DEPTH);
        expOutValidA = 1'b0; expOutDataA = '0;
        expOutValidB = 1'b0; expOutDataB = '0;
        if (s < NCH) begin
            if (oqA[s].size() > 0) begin expOutValidA = 1'b1; expOutDataA = oqA[s][0]; end
            if (oqB[s].size() > 0) begin expOutValidB = 1'b1; expOutDataB = oqB[s][0]; end
        end
        capReadyA = aPushReady; capReadyB = bPushReady;
        capValidA = aOutValid;  capValidB = bOutValid;
        capDataA  = aOutData;   capDataB  = bOutData;
        tkA = outTake && expOutValidA;
        tkB = outTake && expOutValidB;
        expResValid = opValid && (opCode != 2'd0);
        expResData = '0; expErrA = 1'b0; expErrB = 1'b0;
        if (expResValid) begin
            if (c >= NCH) begin
                expErrA = 1'b1; expErrB = 1'b1;
            end else if (opCode == 2'd1) begin
                expResData = W'(inQ[c].size());
            end else if (opCode == 2'd2) begin
                if (inQ[c].size() == 0) begin expErrA = 1'b1; expErrB = 1'b1; end
                else expResData = inQ[c].pop_front();
            end else begin
                if (oqA[c].size() == DEPTH && !(tkA && s == c)) begin
                    void'(oqA[c].pop_front());
                    oqA[c].push_back(opData);
                    if (dropA < 65535) dropA++;
                end else oqA[c].push_back(opData);
                if (oqB[c].size() == DEPTH && !(tkB && s == c)) begin
                    expErrB = 1'b1;
                    if (dropB < 65535) dropB++;
                end else oqB[c].push_back(opData);
            end
        end
        if (tkA) void'(oqA[s].pop_front());
        if (tkB) void'(oqB[s].pop_front());
        if (inPushValid && expReady) inQ[inPushChannel].push_back(inPushData);
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pv, input int pch, input logic [W-1:0] pd,
                         input logic ov, input int oc, input int och, input logic [W-1:0] od,
                         input logic tk, input int sel);
        inPushValid = pv; inPushChannel = CW'(pch); inPushData = pd;
        opValid = ov; opCode = 2'(oc); opChannel = CW'(och); opData = od;
        outTake = tk; outSelect = CW'(sel);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        assertCount++;
        if ({aResValid, aResError, aResData, aDropped, aPushReady, aOutValid} !== {1'b0, 1'b0, 12'd0, 16'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("FAIL reset_a: got v=%0b e=%0b d=%0d drop=%0d rdy=%0b ov=%0b want 0 0 0 0 1 0",
                     aResValid, aResError, aResData, aDropped, aPushReady, aOutValid);
        end
        assertCount++;
        if ({bResValid, bResError, bResData, bDropped, bPushReady, bOutValid} !== {1'b0, 1'b0, 12'd0, 16'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("FAIL reset_b: got v=%0b e=%0b d=%0d drop=%0d rdy=%0b ov=%0b want 0 0 0 0 1 0",
                     bResValid, bResError, bResData, bDropped, bPushReady, bOutValid);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_program();
        logic [W-1:0] sz, w;
        drive(1, 0, 12'd33, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 12'd22, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 12'd11, 0, 0, 0, 0, 0, 0);
        for (int it = 0; it < 6; it++) begin
            drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
            sz = expResData;
            assertCount++;
            if ({aResValid, aResError, aResData} !== {expResValid, expErrA, expResData}) begin
                failCount++;
                $display("FAIL prog_insize: got v=%0b e=%0b d=%0d want v=%0b e=%0b d=%0d",
                         aResValid, aResError, aResData, expResValid, expErrA, expResData);
            end
            if (sz == 0) break;
            drive(0, 0, 0, 1, 2, 0, 0, 0, 0);
            w = expResData;
            assertCount++;
            if ({aResValid, aResError, aResData} !== {expResValid, expErrA, expResData}) begin
                failCount++;
                $display("FAIL prog_in: got v=%0b e=%0b d=%0d want v=%0b e=%0b d=%0d",
                         aResValid, aResError, aResData, expResValid, expErrA, expResData);
            end
            drive(0, 0, 0, 1, 3, 0, sz, 0, 0);
            drive(0, 0, 0, 1, 3, 0, w, 0, 0);
        end
        assertCount++;
        if (aResData !== 12'd0 || aResValid !== 1'b1) begin
            failCount++;
            $display("FAIL prog_final_insize: got v=%0b d=%0d want v=1 d=0", aResValid, aResData);
        end
        exp_q = '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};
        for (int i = 0; i < 6; i++) begin
            w = exp_q.pop_front();
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            assertCount++;
            if (capValidA !== 1'b1 || capDataA !== w) begin
                failCount++;
                $display("FAIL prog_drain[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, capValidA, capDataA, w);
            end
        end
        assertCount++;
        if (aDropped !== 16'd0 || aOutValid !== 1'b0) begin
            failCount++;
            $display("FAIL prog_dropped: got drop=%0d ov=%0b want drop=0 ov=0", aDropped, aOutValid);
        end
    endtask

    task automatic test_in_empty();
        drive(0, 0, 0, 1, 2, 0, 0, 0, 0);
        assertCount++;
        if ({aResValid, aResError, aResData} !== {1'b1, 1'b1, 12'd0}) begin
            failCount++;
            $display("FAIL in_empty: got v=%0b e=%0b d=%0d want v=1 e=1 d=0", aResValid, aResError, aResData);
        end
        drive(1, 0, 12'd5, 1, 2, 0, 0, 0, 0);
        assertCount++;
        if ({bResValid, bResError, bResData} !== {1'b1, 1'b1, 12'd0}) begin
            failCount++;
            $display("FAIL in_push_same_cycle: got v=%0b e=%0b d=%0d want v=1 e=1 d=0", bResValid, bResError, bResData);
        end
        drive(0, 0, 0, 1, 2, 0, 0, 0, 0);
        assertCount++;
        if ({aResValid, aResError, aResData} !== {1'b1, 1'b0, 12'd5}) begin
            failCount++;
            $display("FAIL in_after_push: got v=%0b e=%0b d=%0d want v=1 e=0 d=5", aResValid, aResError, aResData);
        end
    endtask

    task automatic test_out_full();
        logic [W-1:0] wa, wb;
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 1, 3, 1, W'(i), 0, 0);
            assertCount++;
            if (aResError !== 1'b0 || bResError !== expErrB || bResError !== (i > 8)) begin
                failCount++;
                $display("FAIL out_err[%0d]: got a=%0b b=%0b want a=0 b=%0b", i, aResError, bResError, (i > 8));
            end
        end
        exp_q.delete();
        expB_q.delete();
        for (int i = 3; i <= 10; i++) exp_q.push_back(W'(i));
        for (int i = 1; i <= 8; i++) expB_q.push_back(W'(i));
        for (int i = 0; i < 8; i++) begin
            wa = exp_q.pop_front();
            wb = expB_q.pop_front();
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
            assertCount++;
            if (capValidA !== 1'b1 || capDataA !== wa || capValidB !== 1'b1 || capDataB !== wb) begin
                failCount++;
                $display("FAIL out_drain[%0d]: got a=%0b/%0d b=%0b/%0d want a=1/%0d b=1/%0d",
                         i, capValidA, capDataA, capValidB, capDataB, wa, wb);
            end
        end
        assertCount++;
        if (aDropped !== 16'd2 || bDropped !== 16'd2 || aOutValid !== 1'b0) begin
            failCount++;
            $display("FAIL out_dropped: got a=%0d b=%0d ov=%0b want a=2 b=2 ov=0", aDropped, bDropped, aOutValid);
        end
    endtask

    task automatic test_in_full();
        for (int i = 0; i < DEPTH; i++) drive(1, 1, W'(100 + i), 0, 0, 0, 0, 0, 0);
        drive(1, 0, 12'd77, 0, 0, 0, 0, 0, 0);
        assertCount++;
        if (capReadyA !== 1'b1) begin
            failCount++;
            $display("FAIL in_full_ch0_ready: got %0b want 1", capReadyA);
        end
        drive(1, 1, 12'd99, 1, 2, 1, 0, 0, 0);
        assertCount++;
        if (capReadyA !== 1'b0 || capReadyB !== 1'b0 || aResData !== 12'd100 || aResError !== 1'b0) begin
            failCount++;
            $display("FAIL in_full_pop: got rdy=%0b/%0b d=%0d e=%0b want rdy=0/0 d=100 e=0",
                     capReadyA, capReadyB, aResData, aResError);
        end
        drive(1, 1, 12'd99, 0, 0, 0, 0, 0, 0);
        assertCount++;
        if (capReadyA !== 1'b1) begin
            failCount++;
            $display("FAIL in_full_retry_ready: got %0b want 1", capReadyA);
        end
        drive(0, 0, 0, 1, 1, 1, 0, 0, 0);
        assertCount++;
        if (aResData !== W'(DEPTH) || aResData !== expResData) begin
            failCount++;
            $display("FAIL in_full_size: got %0d want %0d", aResData, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), W'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), W'($urandom),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
            assertCount++;
            if (capReadyA !== expReady || capReadyB !== expReady) begin
                failCount++;
                $display("FAIL rnd_ready[%0d]: got %0b/%0b want %0b", i, capReadyA, capReadyB, expReady);
            end
            assertCount++;
            if (capValidA !== expOutValidA || (expOutValidA && capDataA !== expOutDataA)) begin
                failCount++;
                $display("FAIL rnd_out_a[%0d]: got %0b/%0d want %0b/%0d", i, capValidA, capDataA, expOutValidA, expOutDataA);
            end
            assertCount++;
            if (capValidB !== expOutValidB || (expOutValidB && capDataB !== expOutDataB)) begin
                failCount++;
                $display("FAIL rnd_out_b[%0d]: got %0b/%0d want %0b/%0d", i, capValidB, capDataB, expOutValidB, expOutDataB);
            end
            assertCount++;
            if ({aResValid, aResError, aResData} !== {expResValid, expErrA, expResData}) begin
                failCount++;
                $display("FAIL rnd_res_a[%0d]: got %0b/%0b/%0d want %0b/%0b/%0d", i, aResValid, aResError, aResData,
                         expResValid, expErrA, expResData);
            end
            assertCount++;
            if ({bResValid, bResError, bResData} !== {expResValid, expErrB, expResData}) begin
                failCount++;
                $display("FAIL rnd_res_b[%0d]: got %0b/%0b/%0d want %0b/%0b/%0d", i, bResValid, bResError, bResData,
                         expResValid, expErrB, expResData);
            end
            assertCount++;
            if (aDropped !== 16'(dropA) || bDropped !== 16'(dropB)) begin
                failCount++;
                $display("FAIL rnd_dropped[%0d]: got %0d/%0d want %0d/%0d", i, aDropped, bDropped, dropA, dropB);
            end
        end
    endtask

    task automatic test_reset_midop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 2, W'(200 + i), 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 2, 0, 0, 0);
        assertCount++;
        if (aResValid !== 1'b1 || aResData !== expResData) begin
            failCount++;
            $display("FAIL midop_pre: got v=%0b d=%0d want v=1 d=%0d", aResValid, aResData, expResData);
        end
        opValid = 1'b1; opCode = 2'd2; opChannel = 2'd2; outSelect = 2'd2;
        #1;
        reset = 1'b0;
        #1;
        assertCount++;
        if (aResValid !== 1'b0 || bResValid !== 1'b0 || aOutValid !== 1'b0 || aDebug !== 1'b0) begin
            failCount++;
            $display("FAIL midop_reset: got rv=%0b/%0b ov=%0b dbg=%0b want 0/0 0 0", aResValid, bResValid, aOutValid, aDebug);
        end
        opValid = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            drive(0, 0, 0, 1, 1, c, 0, 0, 0);
            assertCount++;
            if ({aResValid, aResError, aResData} !== {1'b1, 1'b0, 12'd0} || bResData !== 12'd0) begin
                failCount++;
                $display("FAIL midop_size[%0d]: got v=%0b e=%0b d=%0d/%0d want 1 0 0", c, aResValid, aResError, aResData, bResData);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, assertions=%0d failures=%0d", assertCount, failCount);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_program();
        test_in_empty();
        test_out_full();
        test_in_full();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/zero_io_channels.md
Name: zero_io_channels

Overview:
- Parametrised input/output channel unit for the zero machine. It replaces the fixed, preloaded 3-word input array and the single wrap-around output array.
- Provides NChannels independent input FIFOs, filled by an external producer, and output FIFOs, drained by an external consumer.
- The instruction executor issues inSize/in/out operations through a single op port and receives registered results.

Parameters:
- MemoryElementWidth, 12, data word width.
- NChannels, 2, number of independent in/out channel pairs (>=1).
- NIn, 8, depth of each input FIFO (power of 2, >=2).
- NOut, 8, depth of each output FIFO (power of 2, >=2).
- OutOverwrite, 1, on output-full: 1 = overwrite the oldest word (wrap-around mode); 0 = reject with error.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- inPushValid  input  1  producer offers a word.
- inPushChannel  input  CW  target channel; CW = max(1,$clog2(NChannels)).
- inPushData  input  MemoryElementWidth  word offered.
- inPushReady  output  1  target input FIFO not full (combinational from inPushChannel).
- opValid  input  1  executor issues an operation.
- opCode  input  2  0 nop, 1 inSize, 2 in, 3 out.
- opChannel  input  CW  channel for the operation.
- opData  input  MemoryElementWidth  word for out.
- resValid  output  1  result valid; exactly one cycle after an accepted non-nop op.
- resData  output  MemoryElementWidth  inSize count or in word; 0 for out.
- resError  output  1  in on empty, or out on full with OutOverwrite=0.
- outValid  output  1  consumer-side FIFO (outSelect) non-empty.
- outSelect  input  CW  channel the consumer drains.
- outData  output  MemoryElementWidth  head word of the selected output FIFO.
- outTake  input  1  pop the head when outValid.
- outDropped  output  16  saturating count of words overwritten or rejected, all channels.

Behaviour:
- Reset (asynchronous assert, synchronous deassert): all FIFO pointers and counts = 0, resValid = 0, resData = 0, resError = 0, outDropped = 0. Combinational outputs follow: inPushReady = 1, outValid = 0. FIFO contents are don't-care. Reset mid-operation discards any pending result and all buffered words.
- Op port is always ready. opValid with opChannel >= NChannels: resValid = 1, resError = 1, no state change.
- Input push: accepted when inPushValid && inPushReady; written at the tail, count += 1. inPushChannel >= NChannels drives inPushReady = 0.
- inSize: resData = count of the channel at the op edge. This excludes a push accepted in the same cycle, consistent with in. Zero-extended or truncated to MemoryElementWidth.
- in, non-empty: resData = head word, pop. The pop is registered, so the result appears the following cycle.
- in, empty: resData = 0, resError = 1, no pop. This remains true even when a push to the same channel occurs in that cycle.
- in and push on the same channel in the same cycle with count > 0: both happen, count unchanged. With count = NIn: inPushReady = 0 already, only the pop occurs.
- out, not full: word written at the tail, resError = 0.
- out, full, OutOverwrite = 1: head advances, then the word is written. Count stays NOut, outDropped += 1, resError = 0.
- out, full, OutOverwrite = 0: word discarded, outDropped += 1, resError = 1.
- Consumer: outData/outValid are combinational from the selected FIFO head. outTake with outValid pops the head.
- out and outTake on the same channel in the same cycle:
  - Both happen.
  - If full, the take frees the slot, so no overwrite or drop occurs.
  - If empty, the written word is not visible until the next cycle.
- Pointers are log2(depth) bits and wrap naturally. Counts are log2(depth)+1 bits.
- outDropped saturates at 16'hFFFF.
- Channels are fully independent; operations on one channel never alter another.
- Per-cycle result register state: IDLE (resValid = 0) or RESP (resValid = 1). It moves to RESP on any accepted non-nop op and otherwise returns to IDLE. Back-to-back ops give back-to-back results.

Test Plan:
1. Push 33, 22, 11 to channel 0. Loop {inSize; if 0 stop; in; out size; out word}. Drain channel 0 and expect output 3, 33, 2, 22, 1, 11. The final inSize returns 0. outDropped = 0.
2. With channel 0 empty, in -> resValid = 1, resError = 1, resData = 0. Then push 5 and issue in in the same cycle -> resError = 1. Next in -> resData = 5.
3. OutOverwrite = 1, NOut = 8: out 1..10 to channel 1 with no takes. Drain and expect 3..10. outDropped = 2.
4. OutOverwrite = 0: same stimulus. The 9th and 10th out return resError = 1. Drain and expect 1..8. outDropped = 2.
5. Fill input channel 1 to NIn -> inPushReady = 0. Channel 0 still accepts pushes. An in on channel 1 plus a push in the same cycle: the push is held off until the next cycle, and the count stays NIn after the push.
6. Assert reset with 4 words buffered and an op in flight -> resValid falls immediately and outValid = 0. After release, inSize returns 0 on every channel.
